// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_e     : arbiter FSM states
//   owner_e     : which requester owns the outstanding read
//   FUNCT3_WORD : access code driven for fetches and while the port is idle
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR      = 2'd2
   } state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data (load/store) requester, with a single transaction in flight.
//
// Parameters
//   MEM_LATENCY  cycles (1..7) from address sample edge to valid mem_read_data
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch accept pulse, read-data pulse, data
//   d_req/d_we/d_funct3/d_addr/d_wdata   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data accept pulse, load-data pulse, data
//   mem_*                          registered memory port drive / read data
//   busy                           high whenever the FSM is not idle
// Configuration
//   ARB_ROUND_ROBIN_EN  defined   : on a tie, grant the requester not granted last
//                       undefined : fixed priority, data over fetch
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_write_mem,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_address,
   input  logic [31:0] mem_read_data,
   output logic        busy
);

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [2:0]  r_cnt;
   owner_e      r_owner;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_wr_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rd_addr;

   logic        w_gnt_if;
   logic        w_gnt_d;
   logic        w_rd_done;

`ifdef ARB_ROUND_ROBIN_EN
   owner_e      r_last_own;
`endif

   // Next state and combinational grants. Grants are masked while reset is
   // asserted so a held request cannot be acknowledged during reset.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_if    = 1'b0;
      w_gnt_d     = 1'b0;
      w_rd_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!reset) begin
`ifdef ARB_ROUND_ROBIN_EN
               if (d_req && if_req) begin
                  w_gnt_d  = (r_last_own == OWN_FETCH);
                  w_gnt_if = (r_last_own == OWN_DATA);
               end else begin
                  w_gnt_d  = d_req;
                  w_gnt_if = if_req;
               end
`else
               w_gnt_d  = d_req;
               w_gnt_if = if_req & ~d_req;
`endif
               if (w_gnt_d)
                  w_state_nxt = d_we ? ST_WR : ST_RD_WAIT;
               else if (w_gnt_if)
                  w_state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            // Counter reaching zero marks the cycle the memory word is valid.
            if (r_cnt == 3'd0) begin
               w_rd_done   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WR:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 3'd0;
         r_owner   <= OWN_FETCH;
         r_we      <= 1'b0;
         r_funct3  <= FUNCT3_WORD;
         r_wr_addr <= 32'd0;
         r_wdata   <= 32'd0;
         r_rd_addr <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_d) begin
                  r_owner  <= OWN_DATA;
                  r_funct3 <= d_funct3;
                  if (d_we) begin
                     r_wr_addr <= d_addr;
                     r_wdata   <= d_wdata;
                     r_we      <= 1'b1;
                  end else begin
                     r_rd_addr <= d_addr;
                     r_cnt     <= LAT;
                  end
               end else if (w_gnt_if) begin
                  r_owner   <= OWN_FETCH;
                  r_funct3  <= FUNCT3_WORD;
                  r_rd_addr <= if_addr;
                  r_cnt     <= LAT;
               end
            end
            ST_RD_WAIT: begin
               // Return the port to its idle drive as the read completes.
               if (r_cnt == 3'd0)
                  r_funct3 <= FUNCT3_WORD;
               else
                  r_cnt <= r_cnt - 3'd1;
            end
            ST_WR: begin
               r_we     <= 1'b0;
               r_funct3 <= FUNCT3_WORD;
            end
            default: ;
         endcase
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_last_own <= OWN_FETCH;
      else if (w_gnt_d)
         r_last_own <= OWN_DATA;
      else if (w_gnt_if)
         r_last_own <= OWN_FETCH;
   end
`endif

   assign if_gnt    = w_gnt_if;
   assign d_gnt     = w_gnt_d;
   assign if_rvalid = w_rd_done & (r_owner == OWN_FETCH);
   assign d_rvalid  = w_rd_done & (r_owner == OWN_DATA);
   assign if_rdata  = if_rvalid ? mem_read_data : 32'd0;
   assign d_rdata   = d_rvalid  ? mem_read_data : 32'd0;

   assign mem_write_mem     = r_we;
   assign mem_funct3        = r_funct3;
   assign mem_write_address = r_wr_addr;
   assign mem_write_data    = r_wdata;
   assign mem_read_address  = r_rd_addr;
   assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Two instances run side by
// side (MEM_LATENCY 1 and 3) on shared stimulus; each test selects one via
// sel and checks its outputs. Memory is modelled as a combinational function
// of the read address.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [2:0]  d_funct3 = 3'd0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_wm, a_busy;
   logic [31:0] a_if_rdata, a_d_rdata, a_wa, a_wd, a_ra, a_mrd;
   logic [2:0]  a_f3;
   logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_wm, b_busy;
   logic [31:0] b_if_rdata, b_d_rdata, b_wa, b_wd, b_ra, b_mrd;
   logic [2:0]  b_f3;

   assign a_mrd = memf(a_ra);
   assign b_mrd = memf(b_ra);

   mem_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
      .mem_write_mem(a_wm), .mem_funct3(a_f3), .mem_write_address(a_wa),
      .mem_write_data(a_wd), .mem_read_address(a_ra), .mem_read_data(a_mrd),
      .busy(a_busy)
   );

   mem_arbiter #(.MEM_LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_write_mem(b_wm), .mem_funct3(b_f3), .mem_write_address(b_wa),
      .mem_write_data(b_wd), .mem_read_address(b_ra), .mem_read_data(b_mrd),
      .busy(b_busy)
   );

   logic        s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_wm, s_busy;
   logic [31:0] s_if_rdata, s_d_rdata, s_wa, s_wd, s_ra;
   logic [2:0]  s_f3;

   assign s_if_gnt    = sel ? b_if_gnt    : a_if_gnt;
   assign s_if_rvalid = sel ? b_if_rvalid : a_if_rvalid;
   assign s_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
   assign s_d_gnt     = sel ? b_d_gnt     : a_d_gnt;
   assign s_d_rvalid  = sel ? b_d_rvalid  : a_d_rvalid;
   assign s_d_rdata   = sel ? b_d_rdata   : a_d_rdata;
   assign s_wm        = sel ? b_wm        : a_wm;
   assign s_f3        = sel ? b_f3        : a_f3;
   assign s_wa        = sel ? b_wa        : a_wa;
   assign s_wd        = sel ? b_wd        : a_wd;
   assign s_ra        = sel ? b_ra        : a_ra;
   assign s_busy      = sel ? b_busy      : a_busy;

   // {d_gnt, d_rvalid, busy} per cycle for two back-to-back loads, latency 3
   logic [2:0] b2b_exp [0:10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic use_b);
      sel = use_b;
      reset = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      reset = 1'b1;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; if_addr = 32'h48;
      @(negedge clk);
      n_checks++; if (s_if_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_if_gnt: got %b exp 0", s_if_gnt); end
      n_checks++; if (s_d_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_d_gnt: got %b exp 0", s_d_gnt); end
      n_checks++; if (s_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", s_busy); end
      n_checks++; if (s_wm !== 1'b0) begin n_errors++; $display("FAIL rst_write_mem: got %b exp 0", s_wm); end
      n_checks++; if (s_f3 !== 3'b010) begin n_errors++; $display("FAIL rst_funct3: got %b exp 010", s_f3); end
      n_checks++; if ({s_ra, s_wa, s_wd} !== 96'd0) begin n_errors++; $display("FAIL rst_addr_data: got %h %h %h exp 0", s_ra, s_wa, s_wd); end
      n_checks++; if ({s_if_rvalid, s_d_rvalid, s_if_rdata, s_d_rdata} !== 66'd0) begin n_errors++; $display("FAIL rst_rvalid: got %b %b exp 0", s_if_rvalid, s_d_rvalid); end
      do_reset(1'b0);
   endtask

   task automatic test_fetch();
      do_reset(1'b0);
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      n_checks++; if ({s_if_gnt, s_d_gnt, s_busy} !== 3'b100) begin n_errors++; $display("FAIL fetch_gnt: got %b exp 100", {s_if_gnt, s_d_gnt, s_busy}); end
      step(); if_req = 1'b0; if_addr = 32'd0;
      @(negedge clk);
      n_checks++; if (s_ra !== 32'h10) begin n_errors++; $display("FAIL fetch_raddr: got %h exp 00000010", s_ra); end
      n_checks++; if ({s_busy, s_f3, s_if_rvalid} !== 5'b1_010_0) begin n_errors++; $display("FAIL fetch_wait: got %b exp 10100", {s_busy, s_f3, s_if_rvalid}); end
      n_checks++; if (s_if_rdata !== 32'd0) begin n_errors++; $display("FAIL fetch_rdata_idle: got %h exp 0", s_if_rdata); end
      step();
      @(negedge clk);
      n_checks++; if (s_if_rvalid !== 1'b1) begin n_errors++; $display("FAIL fetch_rvalid: got %b exp 1", s_if_rvalid); end
      n_checks++; if (s_if_rdata !== memf(32'h10)) begin n_errors++; $display("FAIL fetch_rdata: got %h exp %h", s_if_rdata, memf(32'h10)); end
      n_checks++; if (s_d_rvalid !== 1'b0) begin n_errors++; $display("FAIL fetch_d_rvalid: got %b exp 0", s_d_rvalid); end
      step();
      @(negedge clk);
      n_checks++; if ({s_if_rvalid, s_busy} !== 2'b00) begin n_errors++; $display("FAIL fetch_done: got %b exp 00", {s_if_rvalid, s_busy}); end
   endtask

   task automatic test_store();
      do_reset(1'b0);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
      @(negedge clk);
      n_checks++; if ({s_d_gnt, s_if_gnt} !== 2'b10) begin n_errors++; $display("FAIL store_gnt: got %b exp 10", {s_d_gnt, s_if_gnt}); end
      step(); d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h20;
      @(negedge clk);
      n_checks++; if (s_wm !== 1'b1) begin n_errors++; $display("FAIL store_wm: got %b exp 1", s_wm); end
      n_checks++; if ({s_wa, s_wd, s_f3} !== {32'h400, 32'hDEADBEEF, 3'b010}) begin n_errors++; $display("FAIL store_port: got %h %h %b exp 00000400 deadbeef 010", s_wa, s_wd, s_f3); end
      n_checks++; if ({s_if_gnt, s_busy, s_d_rvalid} !== 3'b010) begin n_errors++; $display("FAIL store_wr_hold: got %b exp 010", {s_if_gnt, s_busy, s_d_rvalid}); end
      step();
      @(negedge clk);
      n_checks++; if ({s_wm, s_if_gnt, s_d_rvalid, s_busy} !== 4'b0100) begin n_errors++; $display("FAIL store_after_wr: got %b exp 0100", {s_wm, s_if_gnt, s_d_rvalid, s_busy}); end
      step(); if_req = 1'b0;
      step();
      @(negedge clk);
      n_checks++; if ({s_if_rvalid, s_if_rdata} !== {1'b1, memf(32'h20)}) begin n_errors++; $display("FAIL store_next_fetch: got %b %h exp 1 %h", s_if_rvalid, s_if_rdata, memf(32'h20)); end
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h402; d_wdata = 32'h0000BEEF; d_funct3 = 3'b001;
      @(negedge clk);
      n_checks++; if (s_d_gnt !== 1'b1) begin n_errors++; $display("FAIL store2_gnt: got %b exp 1", s_d_gnt); end
      step(); d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      n_checks++; if ({s_wm, s_f3, s_wa, s_wd} !== {1'b1, 3'b001, 32'h402, 32'h0000BEEF}) begin n_errors++; $display("FAIL store2_port: got %b %b %h %h exp 1 001 00000402 0000beef", s_wm, s_f3, s_wa, s_wd); end
      step();
      @(negedge clk);
      n_checks++; if ({s_wm, s_f3, s_wa} !== {1'b0, 3'b010, 32'h402}) begin n_errors++; $display("FAIL store2_idle: got %b %b %h exp 0 010 00000402", s_wm, s_f3, s_wa); end
   endtask

   task automatic test_simultaneous();
      logic rr;
`ifdef ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      do_reset(1'b0);
      if_req = 1'b1; if_addr = 32'h30;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h404; d_funct3 = 3'b100;
      @(negedge clk);
      n_checks++; if ({s_d_gnt, s_if_gnt} !== 2'b10) begin n_errors++; $display("FAIL sim_first: got %b exp 10", {s_d_gnt, s_if_gnt}); end
      step(); d_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({s_if_gnt, s_ra, s_f3} !== {1'b0, 32'h404, 3'b100}) begin n_errors++; $display("FAIL sim_load_port: got %b %h %b exp 0 00000404 100", s_if_gnt, s_ra, s_f3); end
      step();
      @(negedge clk);
      n_checks++; if ({s_d_rvalid, s_d_rdata, s_if_gnt} !== {1'b1, memf(32'h404), 1'b0}) begin n_errors++; $display("FAIL sim_d_rvalid: got %b %h %b exp 1 %h 0", s_d_rvalid, s_d_rdata, s_if_gnt, memf(32'h404)); end
      step();
      @(negedge clk);
      n_checks++; if ({s_if_gnt, s_d_gnt, s_d_rvalid} !== 3'b100) begin n_errors++; $display("FAIL sim_if_gnt: got %b exp 100", {s_if_gnt, s_d_gnt, s_d_rvalid}); end
      step(); if_req = 1'b0;
      step();
      @(negedge clk);
      n_checks++; if ({s_if_rvalid, s_if_rdata} !== {1'b1, memf(32'h30)}) begin n_errors++; $display("FAIL sim_if_rvalid: got %b %h exp 1 %h", s_if_rvalid, s_if_rdata, memf(32'h30)); end
      // Lone data load so data becomes the most recently granted requester.
      step();
      d_req = 1'b1; d_addr = 32'h500; d_funct3 = 3'b010;
      @(negedge clk);
      n_checks++; if (s_d_gnt !== 1'b1) begin n_errors++; $display("FAIL sim_lone_gnt: got %b exp 1", s_d_gnt); end
      step(); d_req = 1'b0;
      step();
      step();
      if_req = 1'b1; if_addr = 32'h34; d_req = 1'b1; d_addr = 32'h508;
      @(negedge clk);
      n_checks++; if ({s_if_gnt, s_d_gnt} !== {rr, ~rr}) begin n_errors++; $display("FAIL sim_tie: got %b exp %b", {s_if_gnt, s_d_gnt}, {rr, ~rr}); end
      step();
      if (rr) if_req = 1'b0; else d_req = 1'b0;
      step();
      @(negedge clk);
      if (rr) begin
         n_checks++; if ({s_if_rvalid, s_if_rdata} !== {1'b1, memf(32'h34)}) begin n_errors++; $display("FAIL sim_tie_rv: got %b %h exp 1 %h", s_if_rvalid, s_if_rdata, memf(32'h34)); end
      end else begin
         n_checks++; if ({s_d_rvalid, s_d_rdata} !== {1'b1, memf(32'h508)}) begin n_errors++; $display("FAIL sim_tie_rv: got %b %h exp 1 %h", s_d_rvalid, s_d_rdata, memf(32'h508)); end
      end
      step();
      @(negedge clk);
      n_checks++; if ({s_if_gnt, s_d_gnt} !== {~rr, rr}) begin n_errors++; $display("FAIL sim_tie_second: got %b exp %b", {s_if_gnt, s_d_gnt}, {~rr, rr}); end
      step(); if_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_funct3 = 3'b010;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         n_checks++;
         if ({s_d_gnt, s_d_rvalid, s_busy} !== b2b_exp[c]) begin
            n_errors++; $display("FAIL b2b_cycle%0d: got %b exp %b", c, {s_d_gnt, s_d_rvalid, s_busy}, b2b_exp[c]);
         end
         if (c == 4 || c == 9) begin
            n_checks++;
            if (s_d_rdata !== memf(c == 4 ? 32'h600 : 32'h604)) begin
               n_errors++; $display("FAIL b2b_rdata%0d: got %h exp %h", c, s_d_rdata, memf(c == 4 ? 32'h600 : 32'h604));
            end
         end else if (c == 2) begin
            n_checks++; if (s_d_rdata !== 32'd0) begin n_errors++; $display("FAIL b2b_rdata_idle: got %h exp 0", s_d_rdata); end
         end
         step();
         if (c == 0) d_addr = 32'h604;
         if (c == 5) d_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_funct3 = 3'b010;
      @(negedge clk);
      n_checks++; if (s_d_gnt !== 1'b1) begin n_errors++; $display("FAIL rmid_gnt: got %b exp 1", s_d_gnt); end
      step(); d_req = 1'b0;
      @(negedge clk);
      n_checks++; if (s_busy !== 1'b1) begin n_errors++; $display("FAIL rmid_busy: got %b exp 1", s_busy); end
      step();
      reset = 1'b1;
      #1;
      n_checks++; if ({s_busy, s_d_rvalid, s_if_rvalid, s_wm} !== 4'b0000) begin n_errors++; $display("FAIL rmid_async: got %b exp 0000", {s_busy, s_d_rvalid, s_if_rvalid, s_wm}); end
      step(); reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++; if ({s_d_rvalid, s_if_rvalid, s_busy} !== 3'b000) begin n_errors++; $display("FAIL rmid_after%0d: got %b exp 000", c, {s_d_rvalid, s_if_rvalid, s_busy}); end
         step();
      end
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h1234;
      @(negedge clk);
      step(); d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      n_checks++; if (s_wm !== 1'b1) begin n_errors++; $display("FAIL rmid_wr: got %b exp 1", s_wm); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if ({s_wm, s_busy} !== 2'b00) begin n_errors++; $display("FAIL rmid_wr_abort: got %b exp 00", {s_wm, s_busy}); end
      step(); reset = 1'b0;
      @(negedge clk);
      n_checks++; if ({s_wm, s_busy, s_f3} !== 5'b00_010) begin n_errors++; $display("FAIL rmid_wr_after: got %b exp 00010", {s_wm, s_busy, s_f3}); end
   endtask

   initial begin
      b2b_exp = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b011,
                  3'b100, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
      test_reset();
      test_fetch();
      test_store();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 1, cycles from memory address sample edge to valid mem_read_data (range 1..7).
REQ-002 clk  input  1  system clock; all state on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch requester read request; held with if_addr until if_gnt.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_gnt  output  1  one-cycle pulse; fetch request accepted this edge.
REQ-007 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  data requester request; held with payload until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_funct3  input  3  access size/sign code forwarded to memory.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  one-cycle pulse; data request accepted this edge.
REQ-015 d_rvalid  output  1  one-cycle pulse; load data valid (loads only).
REQ-016 d_rdata  output  32  load data.
REQ-017 mem_write_mem, mem_funct3, mem_write_address, mem_write_data, mem_read_address  output  1/3/32/32/32  registered memory port drive.
REQ-018 mem_read_data  input  32  memory read data.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 States: IDLE, RD_WAIT, WR; exactly one transaction outstanding.
REQ-021 In IDLE, a grant is issued combinationally to at most one requester with req high; no grant outside IDLE, requests held until IDLE.
REQ-022 Read grant edge: mem_read_address <= addr, mem_funct3 <= d_funct3 (data) or 3'b010 (fetch), counter <= MEM_LATENCY, state -> RD_WAIT, owner recorded.
REQ-023 RD_WAIT: counter decrements each cycle; at counter==0 the owner's rvalid is high for one cycle with rdata = mem_read_data, state -> IDLE; grant-to-rvalid latency = MEM_LATENCY+1 cycles.
REQ-024 Store grant edge: mem_write_address, mem_write_data, mem_funct3 registered, mem_write_mem <= 1, state -> WR; WR lasts one cycle, then mem_write_mem <= 0, state -> IDLE; no d_rvalid for stores.
REQ-025 Earliest next grant: cycle after rvalid (read) or cycle after WR (store).
REQ-026 if_rdata/d_rdata SHALL be 0 when the corresponding rvalid is low.
REQ-027 In IDLE, mem_write_mem = 0, mem_funct3 = 3'b010, addresses and write data hold last value.
REQ-028 Addresses pass unmodified; no alignment check.

Reset
REQ-029 Reset asserted: state IDLE, counter 0, all grants/rvalids 0, mem_write_mem 0, mem_funct3 3'b010, addresses/data 0, last-granted = fetch, busy 0.
REQ-030 Reset mid-transaction aborts it; no rvalid or write is issued afterwards for that transaction.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the requester not granted most recently (last-granted register updated on every grant).
REQ-032 Macro undefined: fixed priority, data over fetch; last-granted register absent.

Structure
REQ-033 Package mem_arb_pkg holds state enum, owner enum (OWN_FETCH, OWN_DATA), FUNCT3_WORD = 3'b010.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Fetch only: if_req, if_addr=0x10, MEM_LATENCY=1 -> if_gnt on cycle 0, mem_read_address=0x10 after edge, if_rvalid on cycle 2 with memory word at 0x10.
REQ-036 Store: d_req, d_we=1, d_addr=0x400, d_wdata=0xDEADBEEF, d_funct3=3'b010 -> d_gnt, mem_write_mem high exactly one cycle with those values, no d_rvalid.
REQ-037 Simultaneous if_req and d_req (load 0x404) -> without macro d_gnt first, if_gnt cycle after d_rvalid; with macro and last-granted = data, if_gnt first.
REQ-038 Back-to-back loads, MEM_LATENCY=3 -> d_rvalid 4 cycles after each grant, second d_gnt the cycle after first d_rvalid, busy high throughout each transaction.
REQ-039 Reset asserted during RD_WAIT -> state IDLE immediately, no if_rvalid/d_rvalid, mem_write_mem 0, busy 0.
